// File: rtl/int_to_ieee754_if.sv
// Valid/ready stream bundle for the integer-to-float converter: an integer
// input stream and an IEEE-754 single-precision output stream.
interface int_to_ieee754_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/int_to_ieee754.sv
// Iterative signed 32-bit integer to IEEE-754 single-precision converter.
// Define INT2FP_ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncates.
module int_to_ieee754 #(
  parameter int SHIFT_STEP = 1  // 1, 2, 4, 8 or 16
) (
  input  logic             clk,
  input  logic             reset,
  int_to_ieee754_if.slave  bus,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_reg;
  logic [31:0] mag_reg;
  logic [7:0]  exp_reg;
  logic        sign_reg;
  logic [31:0] out_data_reg;
  logic        out_valid_reg;

  logic [31:0] in_mag;
  logic [4:0]  norm_k;
  logic        norm_found;
  logic [31:0] norm_mag;
  logic [31:0] round_word;

  assign bus.in_ready  = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

  // 0x80000000 negates to itself, which is already the correct magnitude.
  assign in_mag = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;

  // Leading zeros within the top SHIFT_STEP bits, saturating at SHIFT_STEP.
  always_comb begin
    norm_k     = 5'(SHIFT_STEP);
    norm_found = 1'b0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (!norm_found && mag_reg[31-i]) begin
        norm_k     = 5'(i);
        norm_found = 1'b1;
      end
    end
  end

  assign norm_mag = mag_reg << norm_k;

`ifdef INT2FP_ROUND_NEAREST_EN
  logic        round_inc;
  logic [23:0] mant_sum;
  logic        unused_low_bit;

  assign round_inc      = mag_reg[7] & ((|mag_reg[6:0]) | mag_reg[8]);
  assign mant_sum       = {1'b0, mag_reg[30:8]} + {23'd0, round_inc};
  // A carry out leaves the mantissa field at zero and bumps the exponent.
  assign round_word     = {sign_reg, exp_reg + {7'd0, mant_sum[23]}, mant_sum[22:0]};
  assign unused_low_bit = mag_reg[31];
`else
  logic unused_low_bits;

  assign round_word      = {sign_reg, exp_reg, mag_reg[30:8]};
  assign unused_low_bits = ^mag_reg[7:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      mag_reg       <= 32'd0;
      exp_reg       <= 8'd0;
      sign_reg      <= 1'b0;
      out_data_reg  <= 32'd0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sign_reg <= bus.in_data[31];
            mag_reg  <= in_mag;
            exp_reg  <= 8'd158;
            if (in_mag == 32'd0) begin
              out_data_reg  <= 32'd0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (in_mag[31]) begin
              state_reg <= ROUND;
            end else begin
              state_reg <= NORM;
            end
          end
        end
        NORM: begin
          mag_reg <= norm_mag;
          exp_reg <= exp_reg - {3'd0, norm_k};
          if (norm_mag[31]) begin
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          out_data_reg  <= round_word;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_ieee754.sv
// Scoreboard bench for int_to_ieee754: random and directed integers are
// checked against an arithmetic model of the conversion and its latency.
module tb_int_to_ieee754;

  localparam int S = 4;

  typedef struct {
    logic [31:0] din;
    logic [31:0] want;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   bp_mode = 1'b0;
  exp_t sb[$];

  int_to_ieee754_if bus ();

  int_to_ieee754 #(.SHIFT_STEP(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint abs_of(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  function automatic int msb_of(input longint m);
    int p;
    p = -1;
    for (int i = 0; i < 32; i++) if (((m >> i) & 1) != 0) p = i;
    return p;
  endfunction

  // Float value from plain integer arithmetic: scale to 24 significant bits.
  function automatic logic [31:0] ref_float(input logic [31:0] x);
    longint m, q, r, half;
    int p, e, sh;
    m = abs_of(x);
    if (m == 0) return 32'd0;
    p = msb_of(m);
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = longint'(1) << (sh - 1);
`ifdef INT2FP_ROUND_NEAREST_EN
      if (r > half || (r == half && (q & 1) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
`else
      if (r > half) q = q + 0;
`endif
    end
    return {x[31] && m != 0, 8'(e), 23'(q)};
  endfunction

  function automatic int lat_of(input logic [31:0] x);
    longint m;
    int lz;
    m = abs_of(x);
    if (m == 0) return 0;
    lz = 31 - msb_of(m);
    if (lz == 0) return 1;
    return (lz + S - 1) / S + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] v, input logic [31:0] want);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back('{v, want, lat_of(v), cyc + 1});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Random backpressure unless a directed test owns out_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!bp_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop on each new result, then insist the word stays put.
  initial begin
    bit          prev;
    logic [31:0] held;
    exp_t        e;
    prev = 1'b0;
    held = 32'd0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prev = 1'b0;
      end else begin
        if (bus.out_valid && !prev) begin
          if (sb.size() == 0) begin
            check("unexpected_output", bus.out_data, 32'hxxxxxxxx);
          end else begin
            e = sb.pop_front();
            check("data", bus.out_data, e.want);
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            $display("txn in=%h out=%h req=%h lat=%0d", e.din, bus.out_data, e.want, cyc - e.acc);
          end
          held = bus.out_data;
        end else if (bus.out_valid) begin
          check("hold", bus.out_data, held);
        end
        prev = bus.out_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] want;
    int n;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    send(32'h00000001, 32'h3F800000);
    send(32'hFFFFFFFB, 32'hC0A00000);
    send(32'h00000000, 32'h00000000);
    send(32'h80000000, 32'hCF000000);
    send(32'h01000001, 32'h4B800000);
`ifdef INT2FP_ROUND_NEAREST_EN
    send(32'h01000003, 32'h4B800002);
    send(32'h7FFFFFFF, 32'h4F000000);
`else
    send(32'h01000003, 32'h4B800001);
    send(32'h7FFFFFFF, 32'h4EFFFFFF);
`endif

    for (int i = 0; i < 300; i++) begin
      v = $urandom;
      v = v >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
      if ($urandom_range(0, 40) == 0) v = 32'd0;
      send(v, ref_float(v));
    end

    // Backpressure: result must hold and new inputs must be refused.
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    bp_mode = 1'b1;
    bus.out_ready = 1'b0;
    send(32'hFFFFFFFB, 32'hC0A00000);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = $urandom;
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_data", bus.out_data, 32'hC0A00000);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_no_capture_busy", 32'(busy), 32'd0);
    bp_mode = 1'b0;

    // Reset mid-normalisation aborts the conversion outright.
    send(32'h00000001, 32'h3F800000);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    sb.delete();
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    send(32'h00000002, 32'h40000000);

    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
